// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
//   Shared defaults and helpers for the reg_bank_r register bank.
//   DEF_WIDTH / DEF_DEPTH / DEF_RST_VAL : default geometry and reset value.
//   clog2(n) : address width needed to index n entries (never less than 1).
// ---------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_RST_VAL = 0;

  // Elaboration-time helper; a 1-entry bank still gets a 1-bit address.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// ---------------------------------------------------------------------------
// reg_bank_cell
//   One WIDTH-bit storage entry of the register bank.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, loads RST_VAL
//   en      : load d on the next edge
//   clr     : synchronous load of RST_VAL, wins over en
//   d       : write data
//   q       : stored value
// ---------------------------------------------------------------------------
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_r.sv
// ---------------------------------------------------------------------------
// reg_bank_r
//   DEPTH x WIDTH register bank with one write port and two registered read
//   ports. Reads are write-first (same-cycle write data is bypassed), a
//   synchronous clr returns every entry to RST_VAL, and addresses at or above
//   DEPTH are ignored on write and read back as 0 with valid set.
//
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   clr      : synchronous clear of all entries (priority over we)
//   we       : write enable
//   waddr    : write address
//   wdata    : write data
//   re0/re1  : read request per port
//   raddr0/1 : read address per port
//   rdata0/1 : registered read data, holds when the port is idle
//   rvalid0/1: rdata valid, one cycle after the request
// ---------------------------------------------------------------------------
module reg_bank_r
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re0,
  input  logic [clog2(DEPTH)-1:0]   raddr0,
  output logic [WIDTH-1:0]          rdata0,
  output logic                      rvalid0,
  input  logic                      re1,
  input  logic [clog2(DEPTH)-1:0]   raddr1,
  output logic [WIDTH-1:0]          rdata1,
  output logic                      rvalid1
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0] q [DEPTH];
  logic [DEPTH-1:0] wen;

  // Write decode: an address with no matching entry enables nothing, so
  // out-of-range writes fall away without a separate range check.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    assign wen[gi] = we && (waddr == ADDR_W'(gi));

    reg_bank_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wen[gi]),
      .clr     (clr),
      .d       (wdata),
      .q       (q[gi])
    );
  end

  // Read selection for one port. Out-of-range reads give 0; otherwise clr
  // beats the bypass, and the bypass beats the stored value.
  function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_W-1:0] ra);
    logic [WIDTH-1:0] v;
    logic             hit;
    v   = '0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == ADDR_W'(i)) begin
        hit = 1'b1;
        v   = q[i];
      end
    end
    if (!hit) begin
      v = '0;
    end else if (clr) begin
      v = RST_VAL;
    end else if (we && (waddr == ra)) begin
      v = wdata;
    end
    return v;
  endfunction

  // ---- stage p0: combinational read mux with bypass ----
  logic [WIDTH-1:0] rdata0_p0;
  logic [WIDTH-1:0] rdata1_p0;

  assign rdata0_p0 = read_sel(raddr0);
  assign rdata1_p0 = read_sel(raddr1);

  // ---- stage p1: output registers ----
  logic [WIDTH-1:0] rdata0_p1;
  logic [WIDTH-1:0] rdata1_p1;
  logic             vld0_p1;
  logic             vld1_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
    end else begin
      vld0_p1 <= re0;
      vld1_p1 <= re1;
      if (re0) begin
        rdata0_p1 <= rdata0_p0;
      end
      if (re1) begin
        rdata1_p1 <= rdata1_p0;
      end
    end
  end

  assign rdata0  = rdata0_p1;
  assign rdata1  = rdata1_p1;
  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;

endmodule

// File: tb/tb_reg_bank_r.sv
module tb_reg_bank_r;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic        re0 = 1'b0;
  logic        re1 = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr0 = '0;
  logic [2:0]  raddr1 = '0;
  logic [31:0] wdata = '0;

  // a_* : DEPTH=8 instance, b_* : DEPTH=6 instance, same stimulus
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_v0, a_v1, b_v0, b_v1;

  int total = 0;
  int bad   = 0;

  // reference model: plain arrays per instance
  logic [31:0] m  [2][8];
  logic [31:0] ed [2][2];
  logic        ev [2][2];
  int          dep [2];

  always #5 clk = ~clk;

  reg_bank_r #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(a_rd0), .rvalid0(a_v0),
    .re1(re1), .raddr1(raddr1), .rdata1(a_rd1), .rvalid1(a_v1)
  );

  reg_bank_r #(.WIDTH(32), .DEPTH(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(b_rd0), .rvalid0(b_v0),
    .re1(re1), .raddr1(raddr1), .rdata1(b_rd1), .rvalid1(b_v1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_d(input int k, input int p);
    if (k == 0) return (p == 0) ? a_rd0 : a_rd1;
    return (p == 0) ? b_rd0 : b_rd1;
  endfunction

  function automatic logic obs_v(input int k, input int p);
    if (k == 0) return (p == 0) ? a_v0 : a_v1;
    return (p == 0) ? b_v0 : b_v1;
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s_d%0d_rdata%0d", tag, dep[k], p), obs_d(k, p), ed[k][p]);
        chk($sformatf("%s_d%0d_rvalid%0d", tag, dep[k], p),
            {31'b0, obs_v(k, p)}, {31'b0, ev[k][p]});
      end
    end
  endtask

  // Expected read result for the current inputs, before this edge's write.
  function automatic logic [31:0] model_rd(input int k, input logic [2:0] ra);
    if (int'(ra) >= dep[k]) return 32'h0;
    if (clr) return 32'h0;
    if (we && (waddr == ra)) return wdata;
    return m[k][int'(ra)];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        ed[k][p] = 32'h0;
        ev[k][p] = 1'b0;
      end
    end
  endtask

  // One clock: predict outputs, advance model, take the edge, compare.
  task automatic cyc(input string tag);
    for (int k = 0; k < 2; k++) begin
      if (re0) ed[k][0] = model_rd(k, raddr0);
      if (re1) ed[k][1] = model_rd(k, raddr1);
      ev[k][0] = re0;
      ev[k][1] = re1;
    end
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
      end else if (we && (int'(waddr) < dep[k])) begin
        m[k][int'(waddr)] = wdata;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    we = 1'b0; clr = 1'b0; re0 = 1'b0; re1 = 1'b0;
  endtask

  initial begin
    dep[0] = 8;
    dep[1] = 6;
    model_reset();

    // reset state
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    cyc("idle");

    // write then read with one-cycle latency
    we = 1'b1; waddr = 3'd3; wdata = 32'hDEADBEEF;
    cyc("t1_wr");
    idle(); re0 = 1'b1; raddr0 = 3'd3;
    cyc("t1_rd");
    chk("t1_data", a_rd0, 32'hDEADBEEF);
    chk("t1_valid", {31'b0, a_v0}, 32'd1);
    idle();
    cyc("t1_hold");
    chk("t1_hold_data", a_rd0, 32'hDEADBEEF);
    chk("t1_drop_valid", {31'b0, a_v0}, 32'd0);

    // bypass
    we = 1'b1; waddr = 3'd5; wdata = 32'h12345678; re1 = 1'b1; raddr1 = 3'd5;
    cyc("t2_bypass");
    chk("t2_bypass_data", a_rd1, 32'h12345678);
    chk("t2_bypass_data6", b_rd1, 32'h12345678);

    // fill and dual-read same address
    idle();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 32'(i * 32'h11);
      cyc("t3_fill");
    end
    idle(); re0 = 1'b1; re1 = 1'b1; raddr0 = 3'd2; raddr1 = 3'd2;
    cyc("t3_dual");
    chk("t3_port0", a_rd0, 32'h22);
    chk("t3_port1", a_rd1, 32'h22);

    // clr beats write and bypass
    clr = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 32'hFF;
    re0 = 1'b1; raddr0 = 3'd1; re1 = 1'b1; raddr1 = 3'd4;
    cyc("t4_clr");
    chk("t4_clr_bypass", a_rd0, 32'h0);
    idle(); re0 = 1'b1; raddr0 = 3'd1; re1 = 1'b1; raddr1 = 3'd7;
    cyc("t4_after");
    chk("t4_reg1", a_rd0, 32'h0);
    chk("t4_reg7", a_rd1, 32'h0);

    // out-of-range on the 6-entry bank
    idle(); we = 1'b1; waddr = 3'd5; wdata = 32'h55;
    cyc("t5_wr5");
    we = 1'b1; waddr = 3'd7; wdata = 32'h77;
    re0 = 1'b1; raddr0 = 3'd5; re1 = 1'b1; raddr1 = 3'd5;
    cyc("t5_wr7");
    chk("t5_pre", b_rd1, 32'h55);
    idle(); re0 = 1'b1; raddr0 = 3'd7; re1 = 1'b1; raddr1 = 3'd6;
    cyc("t5_oor");
    chk("t5_oor_data", b_rd1, 32'h0);
    chk("t5_oor_valid", {31'b0, b_v1}, 32'd1);
    chk("t5_d8_addr7", a_rd0, 32'h77);
    for (int i = 0; i < 6; i++) begin
      idle(); re0 = 1'b1; raddr0 = 3'(i);
      cyc("t5_scan");
    end
    chk("t5_reg5", b_rd0, 32'h55);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      we     = 1'($urandom_range(0, 1));
      clr    = ($urandom_range(0, 15) == 0);
      waddr  = 3'($urandom_range(0, 7));
      wdata  = $urandom;
      re0    = 1'($urandom_range(0, 1));
      re1    = 1'($urandom_range(0, 1));
      raddr0 = 3'($urandom_range(0, 7));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      cyc("rnd");
    end

    // asynchronous reset in the middle of a read
    idle(); we = 1'b1; waddr = 3'd4; wdata = 32'hA5A5A5A5;
    cyc("t6_wr");
    idle(); re0 = 1'b1; raddr0 = 3'd4;
    cyc("t6_rd");
    chk("t6_before", a_rd0, 32'hA5A5A5A5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, a_v0}, 32'd0);
    chk("t6_async_data", a_rd0, 32'h0);
    chk("t6_async_data6", b_rd0, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(); re0 = 1'b1; raddr0 = 3'd4;
    cyc("t6_after");
    chk("t6_reg4_cleared", a_rd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
